// File: rtl/adc_pkg.sv
// Shared types and frame constants for the 2-channel serial ADC scan controller.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } adc_state_e;

    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned DATA_FIRST_BIT = 5;
    localparam int unsigned DATA_LAST_BIT  = 14;
    localparam int unsigned BIT_IDX_W      = 4;

    localparam logic CMD_START = 1'b1;
    localparam logic CMD_SGL   = 1'b1;
    localparam logic CMD_MSBF  = 1'b1;

    // Command bit driven on din for frame bit k; zero from the null bit onward.
    function automatic logic cmd_bit(input logic [BIT_IDX_W-1:0] k, input logic ch);
        logic v;
        v = 1'b0;
        case (k)
            4'd0:    v = CMD_START;
            4'd1:    v = CMD_SGL;
            4'd2:    v = ch;
            4'd3:    v = CMD_MSBF;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider: CLK_DIV clk cycles per half-period, low half first,
// with rise/fall strobes and a frame bit index. Clears whenever disabled.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rstc_n,
    input  logic                 i_en,
    output logic                 o_sclk,
    output logic                 o_rise_c,
    output logic                 o_fall_c,
    output logic [BIT_IDX_W-1:0] o_bit_idx
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     r_cnt;
    logic                 r_phase;
    logic [BIT_IDX_W-1:0] r_bit;
    logic                 w_half_end;

    assign w_half_end = i_en && (r_cnt == HALF_LAST);
    assign o_rise_c   = w_half_end && !r_phase;
    assign o_fall_c   = w_half_end && r_phase;
    assign o_sclk     = r_phase;
    assign o_bit_idx  = r_bit;

    // Half-period counter, sclk phase and bit index (advances on each falling edge).
    always_ff @(posedge clk or negedge rstc_n) begin
        if (!rstc_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else if (w_half_end) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            if (r_phase) begin
                r_bit <= r_bit + BIT_IDX_W'(1);
            end
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin arbiter, periodic scan scheduler and 16-bit frame sequencer for a
// 2-channel 10-bit serial ADC, with per-channel threshold alarms.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SCAN_PERIOD = 1000,
    parameter int unsigned DATA_W      = 10
) (
    input  logic              clk,
    input  logic              rstc_n,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic              scan_en,
    input  logic [DATA_W-1:0] threshold,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic              adc_din,
    input  logic              adc_dout,
    output logic [DATA_W-1:0] result,
    output logic              result_ch,
    output logic              result_valid,
    output logic [1:0]        alarm,
    output logic              busy
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned TMR_W = $clog2(SCAN_PERIOD);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SCAN_PERIOD - 1);

    adc_state_e           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ch;
    logic                 r_rr;
    logic                 r_din;
    logic                 r_cs_n;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    r_result;
    logic                 r_result_ch;
    logic                 r_valid;
    logic [1:0]           r_gnt;
    logic [1:0]           r_alarm;
    logic                 r_busy;
    logic [1:0]           r_pending;
    logic [TMR_W-1:0]     r_timer;

    logic [1:0]           w_cand;
    logic                 w_pick;
    logic                 w_tick;
    logic                 w_sclk_en;
    logic                 w_sclk;
    logic                 w_rise;
    logic                 w_fall;
    logic [BIT_IDX_W-1:0] w_bit;
    logic                 w_data_bit;
    logic                 w_last_bit;

    assign w_cand     = req | r_pending;
    // On a tie the channel after the last served one wins.
    assign w_pick     = (&w_cand) ? ~r_rr : w_cand[1];
    assign w_tick     = scan_en && (r_timer == TMR_LAST);
    assign w_sclk_en  = (r_state == SHIFT);
    assign w_data_bit = (w_bit >= BIT_IDX_W'(DATA_FIRST_BIT)) && (w_bit <= BIT_IDX_W'(DATA_LAST_BIT));
    assign w_last_bit = (w_bit == BIT_IDX_W'(FRAME_BITS - 1));

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rstc_n    (rstc_n),
        .i_en      (w_sclk_en),
        .o_sclk    (w_sclk),
        .o_rise_c  (w_rise),
        .o_fall_c  (w_fall),
        .o_bit_idx (w_bit)
    );

    assign adc_sclk     = w_sclk;
    assign adc_cs_n     = r_cs_n;
    assign adc_din      = r_din;
    assign result       = r_result;
    assign result_ch    = r_result_ch;
    assign result_valid = r_valid;
    assign gnt          = r_gnt;
    assign alarm        = r_alarm;
    assign busy         = r_busy;

    // Auto-scan timer: free-runs while enabled, cleared when disabled.
    always_ff @(posedge clk or negedge rstc_n) begin
        if (!rstc_n) begin
            r_timer <= '0;
        end else if (!scan_en) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Pending scan requests: a tick re-arms both channels and beats a same-cycle clear.
    always_ff @(posedge clk or negedge rstc_n) begin
        if (!rstc_n) begin
            r_pending <= 2'b00;
        end else if (w_tick) begin
            r_pending <= 2'b11;
        end else if (r_state == DONE) begin
            r_pending[r_ch] <= 1'b0;
        end
    end

    // Frame sequencer with registered link, result and alarm outputs.
    always_ff @(posedge clk or negedge rstc_n) begin
        if (!rstc_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ch        <= 1'b0;
            r_rr        <= 1'b1;
            r_din       <= 1'b0;
            r_cs_n      <= 1'b1;
            r_shift     <= '0;
            r_result    <= '0;
            r_result_ch <= 1'b0;
            r_valid     <= 1'b0;
            r_gnt       <= 2'b00;
            r_alarm     <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_gnt   <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|w_cand) begin
                        r_state <= SETUP;
                        r_ch    <= w_pick;
                        r_rr    <= w_pick;
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b0;
                        r_din   <= CMD_START;
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (w_rise && w_data_bit) begin
                        r_shift <= {r_shift[DATA_W-2:0], adc_dout};
                    end
                    if (w_fall) begin
                        if (w_last_bit) begin
                            r_state     <= DONE;
                            r_cs_n      <= 1'b1;
                            r_din       <= 1'b0;
                            r_result    <= r_shift;
                            r_result_ch <= r_ch;
                            r_valid     <= 1'b1;
                            r_gnt       <= r_ch ? 2'b10 : 2'b01;
                        end else begin
                            r_din <= cmd_bit(w_bit + BIT_IDX_W'(1), r_ch);
                        end
                    end
                end
                DONE: begin
                    r_alarm[r_ch] <= (r_result > threshold);
                    r_state       <= HOLD;
                    r_cnt         <= '0;
                end
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cs_n  <= 1'b1;
                    r_din   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural serial ADC and sclk/din audit.
module tb_adc_scan_ctrl;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned SCAN_PERIOD = 200;
    localparam int unsigned DATA_W      = 10;
    localparam int          LAT         = 33 * CLK_DIV;
    localparam int          SPACING     = 2 + 35 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rstc_n = 1'b0;
    logic [1:0]        req = 2'b00;
    logic [1:0]        gnt;
    logic              scan_en = 1'b0;
    logic [DATA_W-1:0] threshold = '0;
    logic              adc_sclk;
    logic              adc_cs_n;
    logic              adc_din;
    logic              adc_dout = 1'b0;
    logic [DATA_W-1:0] result;
    logic              result_ch;
    logic              result_valid;
    logic [1:0]        alarm;
    logic              busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_v = 0;

    logic [9:0] adc_val [2];
    logic [9:0] cur_val = '0;
    logic [3:0] m_cmd = '0;
    int         m_k = 0;

    bit   audit_on = 1'b1;
    int   a_run = 0, a_rises = 0, a_frames = 0;
    bit   a_seen = 1'b0;
    logic a_prev_sclk = 1'b0, a_prev_din = 1'b0, a_prev_cs = 1'b1;
    int   bad_half = 0, bad_din = 0, bad_rise = 0, valid_cnt = 0;

    adc_scan_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .SCAN_PERIOD (SCAN_PERIOD),
        .DATA_W      (DATA_W)
    ) dut (
        .clk          (clk),
        .rstc_n       (rstc_n),
        .req          (req),
        .gnt          (gnt),
        .scan_en      (scan_en),
        .threshold    (threshold),
        .adc_sclk     (adc_sclk),
        .adc_cs_n     (adc_cs_n),
        .adc_din      (adc_din),
        .adc_dout     (adc_dout),
        .result       (result),
        .result_ch    (result_ch),
        .result_valid (result_valid),
        .alarm        (alarm),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: captures command bits on sclk rise, presents D9..D0 for bits 5..14.
    always @(negedge adc_cs_n or posedge adc_sclk) begin
        if (adc_sclk !== 1'b1) begin
            m_k      = 0;
            m_cmd    = '0;
            cur_val  = '0;
            adc_dout = 1'b0;
        end else if (adc_cs_n === 1'b0) begin
            if (m_k < 4) m_cmd[3-m_k] = adc_din;
            if (m_k < 16) m_k++;
            if (m_k == 3) cur_val = adc_val[m_cmd[1]];
            adc_dout = (m_k >= 5 && m_k <= 14) ? cur_val[14-m_k] : 1'b0;
        end
    end

    // Link audit: half-period widths, rising edges per frame, din stable while sclk high.
    always @(negedge clk) begin
        if (result_valid === 1'b1) valid_cnt++;
        if (audit_on) begin
            if (adc_sclk !== a_prev_sclk) begin
                if (a_prev_sclk === 1'b1) begin
                    if (a_run != CLK_DIV) bad_half++;
                end else if (a_seen) begin
                    if (a_run != CLK_DIV) bad_half++;
                end
                if (adc_sclk === 1'b1) begin
                    a_rises++;
                    a_seen = 1'b1;
                end
                a_run = 1;
            end else begin
                a_run++;
            end
            if (adc_sclk === 1'b1 && adc_din !== a_prev_din) bad_din++;
            if (a_prev_cs === 1'b0 && adc_cs_n === 1'b1) begin
                if (a_rises != 16) bad_rise++;
                a_frames++;
                a_rises = 0;
                a_seen  = 1'b0;
            end
        end
        a_prev_sclk = adc_sclk;
        a_prev_din  = adc_din;
        a_prev_cs   = adc_cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstc_n = 1'b0;
        repeat (2) @(negedge clk);
        rstc_n = 1'b1;
        @(negedge clk);
    endtask

    // Follow one frame from cs_n fall through the end of HOLD, checking result and timing.
    task automatic run_frame(input string tag, input logic exp_ch, input logic [9:0] exp_val,
                             input logic [1:0] exp_alarm, input bit drop_req);
        int n;
        int hi;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 32'(n < 2000), 32'd1);
        if (n >= 2000) return;
        n = 0;
        while (result_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
        if (n >= 2000) return;
        last_v = cyc;
        chk({tag, "_result"}, 32'(result), 32'(exp_val));
        chk({tag, "_ch"}, 32'(result_ch), 32'(exp_ch));
        chk({tag, "_gnt"}, 32'(gnt), exp_ch ? 32'd2 : 32'd1);
        chk({tag, "_cmd"}, 32'(m_cmd), 32'({1'b1, 1'b1, exp_ch, 1'b1}));
        chk({tag, "_rises"}, m_k, 16);
        if (drop_req) req = 2'b00;
        @(negedge clk);
        chk({tag, "_alarm"}, 32'(alarm), 32'(exp_alarm));
        chk({tag, "_strobe"}, 32'(result_valid), 32'd0);
        hi = 0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            if (adc_cs_n === 1'b1) hi++;
            if (i < 2 * CLK_DIV - 1) @(negedge clk);
        end
        chk({tag, "_cs_hold"}, hi, 2 * CLK_DIV);
    endtask

    initial begin
        int p;
        int v0;
        adc_val[0] = '0;
        adc_val[1] = '0;

        // Reset values while rstc_n is low.
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rst_sclk", 32'(adc_sclk), 32'd0);
        chk("rst_din", 32'(adc_din), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_ch", 32'(result_ch), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstc_n = 1'b1;
        @(negedge clk);

        // Single ch0 request, value 0x2A5 above threshold 37.
        threshold  = 10'd37;
        adc_val[0] = 10'h2A5;
        req        = 2'b01;
        run_frame("t1", 1'b0, 10'h2A5, 2'b01, 1'b1);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Both channels held: alternate from ch0 after reset; 37 is not above 37.
        do_reset();
        adc_val[0] = 10'd37;
        adc_val[1] = 10'd38;
        req        = 2'b11;
        run_frame("t2a", 1'b0, 10'd37, 2'b00, 1'b0);
        p = last_v;
        run_frame("t2b", 1'b1, 10'd38, 2'b10, 1'b0);
        chk("t2_spacing", last_v - p, SPACING);
        adc_val[1] = 10'd37;
        run_frame("t2c", 1'b0, 10'd37, 2'b10, 1'b0);
        run_frame("t2d", 1'b1, 10'd37, 2'b00, 1'b1);

        // Auto-scan: ch0 then ch1; second tick lands during ch1 frame and re-serves ch0.
        adc_val[0] = 10'h3FF;
        adc_val[1] = 10'd0;
        scan_en    = 1'b1;
        run_frame("t3a", 1'b0, 10'h3FF, 2'b01, 1'b0);
        run_frame("t3b", 1'b1, 10'd0, 2'b01, 1'b0);
        scan_en = 1'b0;
        p = last_v;
        run_frame("t3c", 1'b0, 10'h3FF, 2'b01, 1'b0);
        chk("t3_spacing", last_v - p, SPACING);
        repeat (150) @(negedge clk);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        chk("audit_half", bad_half, 0);
        chk("audit_din", bad_din, 0);
        chk("audit_rises", bad_rise, 0);
        chk("audit_frames", a_frames, 8);
        audit_on = 1'b0;

        // Abort mid-frame during the high half of bit 8.
        req = 2'b01;
        p = 0;
        while (adc_cs_n !== 1'b0 && p < 2000) begin
            @(negedge clk);
            p++;
        end
        repeat (CLK_DIV + 70) @(negedge clk);
        req = 2'b00;
        chk("t4_pre_sclk", 32'(adc_sclk), 32'd1);
        v0 = valid_cnt;
        #2 rstc_n = 1'b0;
        #1;
        chk("t4_cs_n", 32'(adc_cs_n), 32'd1);
        chk("t4_sclk", 32'(adc_sclk), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_no_valid", valid_cnt, v0);
        adc_val[0] = 10'd100;
        req        = 2'b11;
        rstc_n     = 1'b1;
        run_frame("t4", 1'b0, 10'd100, 2'b01, 1'b1);

        // Scan tick coincident with ch1 DONE keeps ch1 pending for the next round.
        adc_val[1] = 10'd500;
        @(negedge clk);
        scan_en = 1'b1;
        repeat (66) @(negedge clk);
        req = 2'b10;
        run_frame("t5a", 1'b1, 10'd500, 2'b11, 1'b1);
        run_frame("t5b", 1'b0, 10'd100, 2'b11, 1'b0);
        scan_en = 1'b0;
        run_frame("t5c", 1'b1, 10'd500, 2'b11, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Controller and arbiter for the 2-channel 10-bit serial ADC link: adc_sclk, adc_cs_n, adc_din and adc_dout.
- Shares the converter between two channel requesters using round-robin arbitration.
- Optionally auto-schedules periodic scans of both channels.
- Sequences each 16-bit conversion frame, returns the result with a valid strobe, and maintains per-channel threshold alarms that drive the board LEDs.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (legal range 2..255).
- SCAN_PERIOD, 1000, clk cycles between auto-scan ticks when scan_en=1 (must be >=2).
- DATA_W, 10, ADC result width (fixed by the device; not to be changed).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstc_n  in  1  asynchronous, active-low reset.
- req  in  2  per-channel conversion request; level, held until matching gnt.
- gnt  out  2  one-hot, one-cycle pulse coincident with result_valid for the served channel.
- scan_en  in  1  enables the periodic auto-scan timer.
- threshold  in  DATA_W  alarm threshold; sampled in the DONE cycle.
- adc_sclk  out  1  serial clock to ADC; idles low.
- adc_cs_n  out  1  chip select, active low.
- adc_din  out  1  command bit to ADC.
- adc_dout  in  1  data bit from ADC.
- result  out  DATA_W  last conversion value.
- result_ch  out  1  channel of the last conversion.
- result_valid  out  1  one-cycle strobe.
- alarm  out  2  alarm[ch] = 1 when last result(ch) > threshold (strict).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, rstc_n=0):
  - adc_cs_n=1, adc_sclk=0, adc_din=0.
  - gnt=0, result=0, result_ch=0, result_valid=0, alarm=0, busy=0.
  - pending=0, scan timer=0, rr pointer=1 (so ch0 wins first).
  - Assertion mid-frame aborts the frame: cs_n rises and sclk drops immediately; no result_valid or gnt is produced.
- States: IDLE -> SETUP -> SHIFT -> DONE -> HOLD -> IDLE.
- IDLE:
  - Candidate set = req | pending.
  - If non-empty, grant the channel after the rr pointer: on a tie, choose ch ≠ last served.
  - Latch the channel, update the rr pointer, go to SETUP.
- SETUP:
  - Lasts CLK_DIV cycles.
  - cs_n=0, sclk=0, din = bit0 of the command.
- SHIFT:
  - 16 sclk periods; each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - din changes only at the start of a low half.
  - adc_dout is sampled on the clk edge that drives sclk 0->1.
  - Bit index k=0..15:
    - k0 start=1, k1 SGL=1, k2 ODD=ch, k3 MSBF=1 driven on din.
    - k4 null bit: ignored.
    - k5..k14 data D9..D0, shifted in MSB-first.
    - k15 don't-care; din=0 from k4 onward.
- DONE (1 cycle):
  - cs_n=1, sclk=0.
  - result/result_ch updated; result_valid=1; gnt[ch]=1.
  - alarm[ch] <= (result > threshold); the other alarm bit is held.
  - pending[ch] cleared.
- HOLD:
  - 2*CLK_DIV cycles with cs_n=1 (device CS-high minimum), then IDLE.
- Latency:
  - The IDLE decision cycle is t0; result_valid occurs at t0+1+33*CLK_DIV (t0+133 at CLK_DIV=4).
  - Back-to-back frame spacing is 1+33*CLK_DIV+1+2*CLK_DIV cycles (142 at CLK_DIV=4).
- Scan timer:
  - Counts 0..SCAN_PERIOD-1 while scan_en=1 and wraps; at wrap it sets pending=2'b11.
  - scan_en=0 clears the timer but not pending.
  - A tick during a frame only sets pending; it does not disturb the frame.
  - A tick in the same cycle as DONE for ch: the tick wins (pending[ch] stays 1).
- Requesters:
  - Must hold req until gnt. A req dropped early is a protocol error; the frame completes regardless.
  - req and pending for the same channel merge into one conversion.
- threshold is unregistered and compared in the DONE cycle only.

Decomposition:
- Package adc_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, DONE, HOLD);
  - FRAME_BITS=16, DATA_FIRST_BIT=5, DATA_LAST_BIT=14;
  - command bit constants START/SGL/MSBF.
- Sub-module adc_sclk_gen: a CLK_DIV half-period divider enabled by the FSM. It outputs adc_sclk, a rise strobe, a fall strobe and a 4-bit bit index, and clears synchronously when disabled.

Test Plan:
- Single req[0] pulse-held, ADC model returns 10'h2A5, threshold=37 -> at CLK_DIV=4:
  - din sequence 1,1,0,1 on k0..k3;
  - result_valid at t0+133 with result=10'h2A5, result_ch=0, gnt=2'b01, alarm=2'b01;
  - cs_n high for ≥8 cycles after DONE.
- req=2'b11 held continuously -> grants alternate 0,1,0,1; alarm[1] set only if ch1 value (10'd38) > 37; value 10'd37 leaves alarm clear.
- scan_en=1, SCAN_PERIOD=200, no req -> two conversions (ch0 then ch1) per tick; tick during a frame is serviced after HOLD.
- rstc_n asserted at SHIFT k8 -> cs_n=1 and sclk=0 within the same cycle; no result_valid; after release, ch0 is served first.
- Tick coincident with DONE of ch1 -> ch1 converted again in the next round.
- sclk audit: every high and low half is exactly CLK_DIV cycles; 16 rising edges per frame; din never changes while sclk=1.
